psum_drain: RTL and testbench

- Sits at the bottom of a PE column and consumes the partial-sum stream leaving the last PE.
- Accumulates that stream element-wise over a programmable number of passes (K-tiling) in a local buffer.
- Then drains the final sums to the output/writeback path over a valid/ready handshake.
- The column cannot stall, so the input side has no backpressure.

---
 rtl/psum_drain_pkg.sv | 13 +
 rtl/adder.sv | 12 +
 rtl/psum_buffer.sv | 25 ++
 rtl/psum_drain.sv | 130 +++++++++++++
 tb/tb_psum_drain.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/psum_drain_pkg.sv
// Shared types and constants for the partial-sum accumulate/drain block.
package psum_drain_pkg;
  localparam int ACC_W_DEF  = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int PASS_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  // Two's-complement add overflow from the operand and result sign bits.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction
endpackage

// File: rtl/adder.sv
// Plain ripple-style adder with carry in/out; synthesis picks the structure.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
endmodule

// File: rtl/psum_buffer.sv
// Accumulation buffer: one synchronous write port, two combinational read ports.
module psum_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] acc_addr,
  output logic [W-1:0]     acc_data,
  input  logic [IDX_W-1:0] drn_addr,
  output logic [W-1:0]     drn_data
);
  // Contents are deliberately not reset; every entry is overwritten in pass 0.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign acc_data = mem[acc_addr];
  assign drn_data = mem[drn_addr];
endmodule

// File: rtl/psum_drain.sv
// Accumulates a PE-column psum stream over K passes, then drains final sums over valid/ready.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int accumulationPar = ACC_W_DEF,
  parameter int DEPTH           = DEPTH_DEF,
  parameter int PASS_W          = PASS_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
  input  logic [PASS_W-1:0]          cfg_passes,
  input  logic [accumulationPar-1:0] psum_in,
  input  logic                       psum_valid,
  output logic [accumulationPar-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       drop_err
);
  localparam int W     = accumulationPar;
  localparam int LEN_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  state_e            state;
  logic [LEN_W-1:0]  len;
  logic [PASS_W-1:0] passes, pass;
  logic [IDX_W-1:0]  idx, rd, drn_addr;
  logic [W-1:0]      acc_q, sum, wdata, drn_q;
  logic              unused_carry;
  logic              acc_fire, last_idx, last_pass, last_rd, cfg_ok;

  assign acc_fire  = (state == ACCUM) && psum_valid;
  assign last_idx  = (LEN_W'(idx) == len - LEN_W'(1));
  assign last_pass = (pass == passes - PASS_W'(1));
  assign last_rd   = (LEN_W'(rd) == len - LEN_W'(1));
  assign cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH)) && (cfg_passes != '0);
  assign wdata     = (pass == '0) ? psum_in : sum;
  // Drain port looks one entry ahead so the next word is registered on each handshake.
  assign drn_addr  = (state == DRAIN) ? rd + IDX_W'(1) : '0;

  adder #(.WIDTH(W)) u_add (
    .a        (acc_q),
    .b        (psum_in),
    .carry_in (1'b0),
    .sum      (sum),
    .carry_out(unused_carry)
  );

  psum_buffer #(.W(W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_buf (
    .clk     (clk),
    .we      (acc_fire),
    .waddr   (idx),
    .wdata   (wdata),
    .acc_addr(idx),
    .acc_data(acc_q),
    .drn_addr(drn_addr),
    .drn_data(drn_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      passes    <= '0;
      pass      <= '0;
      idx       <= '0;
      rd        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (psum_valid && state != ACCUM) drop_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            len      <= cfg_len;
            passes   <= cfg_passes;
            idx      <= '0;
            pass     <= '0;
            rd       <= '0;
            overflow <= 1'b0;
            drop_err <= psum_valid;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (psum_valid) begin
            if (pass != '0 && add_ovf(acc_q[W-1], psum_in[W-1], sum[W-1])) overflow <= 1'b1;
            if (last_idx) begin
              idx  <= '0;
              pass <= pass + PASS_W'(1);
              if (last_pass) begin
                state     <= DRAIN;
                rd        <= '0;
                out_valid <= 1'b1;
                // Entry 0 is only being written this cycle when len==1; bypass it.
                out_data  <= (idx == '0) ? wdata : drn_q;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_rd) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              rd       <= rd + IDX_W'(1);
              out_data <= drn_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_drain.sv
// Directed + randomized bench for psum_drain with a queue/arithmetic reference model.
module tb_psum_drain;
  logic        clk = 1'b0;
  logic        rst, start, psum_valid, out_ready;
  logic [4:0]  cfg_len;
  logic [7:0]  cfg_passes;
  logic [31:0] psum_in, out_data;
  logic        out_valid, busy, done, overflow, drop_err;

  int checks = 0;
  int failures = 0;
  int stim[$];

  psum_drain dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_passes(cfg_passes),
    .psum_in(psum_in), .psum_valid(psum_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one full job using stim[p*len+i] as the psum stream.
  task automatic run_job(input int len, input int passes, input int gap_pct, input int rdy_mode,
                         input bit drop_in_drain, input bit start_in_accum);
    longint      acc [16];
    logic [31:0] expv [16];
    longint      r;
    bit          ovf;
    int          k, cyc, g;
    logic [31:0] e;
    ovf = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++) begin
        if (p == 0) acc[i] = longint'(stim[p*len+i]);
        else begin
          r = acc[i] + longint'(stim[p*len+i]);
          if (r > 64'sd2147483647 || r < -64'sd2147483648) ovf = 1;
          acc[i] = longint'(int'(r));
        end
      end
    for (int i = 0; i < len; i++) expv[i] = acc[i][31:0];

    start = 1; cfg_len = 5'(len); cfg_passes = 8'(passes);
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("ovf_clear_on_start", overflow, 0);
    chk("drop_clear_on_start", drop_err, 0);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++) begin
        g = 0;
        while (g < 4 && $urandom_range(99) < gap_pct) begin
          psum_valid = 0;
          @(negedge clk);
          chk("no_valid_in_accum", out_valid, 0);
          g++;
        end
        psum_valid = 1; psum_in = stim[p*len+i];
        if (start_in_accum && p == 0 && i == 0) begin
          start = 1; cfg_len = 5'd1; cfg_passes = 8'd1;
        end
        @(negedge clk);
        start = 0;
        if (!(p == passes-1 && i == len-1)) begin
          chk("no_valid_in_accum", out_valid, 0);
          chk("busy_in_accum", busy, 1);
        end
      end
    psum_valid = 0;

    k = 0; cyc = 0;
    while (k < len && cyc < 400) begin
      e = expv[k];
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, e);
      chk("no_done_in_drain", done, 0);
      case (rdy_mode)
        0: out_ready = 1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(1));
      endcase
      psum_valid = 0;
      if (drop_in_drain && cyc == 0) begin
        out_ready = 0; psum_valid = 1; psum_in = $urandom;
      end
      @(negedge clk);
      if (out_ready) k++;
      cyc++;
    end
    psum_valid = 0; out_ready = 0;
    chk("drain_complete", k, len);
    chk("done_pulse", done, 1);
    chk("valid_low_at_done", out_valid, 0);
    chk("busy_low_at_done", busy, 0);
    chk("overflow_flag", overflow, ovf);
    chk("drop_flag", drop_err, drop_in_drain);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rst = 1; start = 0; cfg_len = 0; cfg_passes = 0;
    psum_in = 0; psum_valid = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_err", drop_err, 0);
    rst = 0;
    @(negedge clk);

    // Single pass, no gaps, always ready.
    stim = '{1, 2, 3, 4};
    run_job(4, 1, 0, 0, 0, 0);

    // Three passes with random gaps: 30, -15, 21.
    stim = '{10, -5, 7, 10, -5, 7, 10, -5, 7};
    run_job(3, 3, 40, 0, 0, 0);

    // Backpressure 1,0,0,1 pattern.
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(int'($urandom_range(1000)) - 500);
    run_job(5, 2, 0, 1, 0, 0);

    // Overflow wrap, then a clean job clears the flag.
    stim = '{32'h7FFFFFFF, 1};
    run_job(1, 2, 0, 0, 0, 0);
    stim = '{3, 4};
    run_job(2, 1, 0, 0, 0, 0);

    // Illegal configurations must not start a job.
    begin
      int bad_len[3] = '{0, 17, 4};
      int bad_pas[3] = '{1, 1, 0};
      for (int t = 0; t < 3; t++) begin
        start = 1; cfg_len = 5'(bad_len[t]); cfg_passes = 8'(bad_pas[t]);
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("illegal_start_ignored", busy, 0);
      end
    end

    // psum_valid in IDLE sets the sticky drop flag.
    psum_valid = 1; psum_in = 32'd99;
    @(negedge clk);
    psum_valid = 0;
    chk("drop_in_idle", drop_err, 1);

    // Drop during DRAIN plus a start issued mid-ACCUM.
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(int'($urandom));
    run_job(4, 2, 20, 2, 1, 1);

    // Reset mid-job during pass 1 after an overflowing add.
    start = 1; cfg_len = 5'd3; cfg_passes = 8'd2;
    @(negedge clk);
    start = 0;
    begin
      int seq[4] = '{32'h7FFFFFFF, 0, 0, 1};
      for (int i = 0; i < 4; i++) begin
        psum_valid = 1; psum_in = seq[i];
        @(negedge clk);
      end
    end
    psum_valid = 0;
    chk("ovf_before_abort", overflow, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_drop_err", drop_err, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_no_done", done, 0);
    stim = '{5, 6};
    run_job(2, 1, 0, 0, 0, 0);

    // Randomized jobs including a full-depth one.
    for (int j = 0; j < 5; j++) begin
      int len, pas;
      len = (j == 0) ? 16 : int'($urandom_range(16, 1));
      pas = int'($urandom_range(4, 1));
      stim.delete();
      for (int i = 0; i < len*pas; i++)
        stim.push_back((j % 2 == 0) ? int'($urandom) : int'($urandom_range(2000)) - 1000);
      run_job(len, pas, 30, 2, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
